// File: rtl/axis_status_pio_pkg.sv
// Shared constants for the axis status PIO: register map and edge-type encodings.
package axis_status_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_FILT = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/axis_status_filt.sv
// One status bit: 2-flop synchronizer followed by a consecutive-cycle glitch filter.
module axis_status_filt #(
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_bit,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              cnt_clr,
    output logic              filt_out
);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              filt_q, filt_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic [FILT_W:0]   cnt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sync1_d  = in_bit;
        sync2_d  = sync1_q;
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        cnt_next = {1'b0, cnt_q} + 1'b1;
        // In bypass the filtered flop still tracks, so re-enabling the filter causes no false change.
        if (filt_len == '0) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_clr || (sync2_q == filt_q)) begin
            cnt_d = '0;
        end else if (cnt_next >= {1'b0, filt_len}) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_next[FILT_W-1:0];
        end
    end

    assign filt_out = (filt_len == '0) ? sync2_q : filt_q;

endmodule

// File: rtl/axis_status_pio.sv
// Axis status PIO: filtered status inputs, edge capture with write-1-to-clear, masked level irq.
module axis_status_pio
    import axis_status_pio_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = 0,
    parameter int FILT_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    logic              wr_en, rd_en, filt_wr;
    logic [WIDTH-1:0]  filt_val;
    logic [WIDTH-1:0]  edge_det;
    logic [WIDTH-1:0]  edge_clr;
    logic [WIDTH-1:0]  rd_mux;
    logic [WIDTH-1:0]  filt_len_rd;
    logic [FILT_W-1:0] filt_len_wr;

    logic [WIDTH-1:0]  filt_dly_q, filt_dly_d;
    logic [WIDTH-1:0]  edge_q, edge_d;
    logic [WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0]  irq_mask_q, irq_mask_d;
    logic [FILT_W-1:0] filt_len_q, filt_len_d;
    logic [WIDTH-1:0]  readdata_q, readdata_d;

    assign wr_en   = chipselect & ~write_n;
    assign rd_en   = chipselect & ~read_n;
    assign filt_wr = wr_en && (address == ADDR_FILT);

    for (genvar i = 0; i < WIDTH; i++) begin : g_filt
        axis_status_filt #(.FILT_W(FILT_W)) u_filt (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_bit   (in_port[i]),
            .filt_len (filt_len_q),
            .cnt_clr  (filt_wr),
            .filt_out (filt_val[i])
        );
    end

    // Map filt_len between the WIDTH-bit bus and the FILT_W-bit register.
    if (FILT_W >= WIDTH) begin : g_len_wide
        assign filt_len_rd = filt_len_q[WIDTH-1:0];
        assign filt_len_wr = {{(FILT_W-WIDTH){1'b0}}, writedata};
    end else begin : g_len_narrow
        assign filt_len_rd = {{(WIDTH-FILT_W){1'b0}}, filt_len_q};
        assign filt_len_wr = writedata[FILT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_dly_q <= '0;
            edge_q     <= '0;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            filt_len_q <= '0;
            readdata_q <= '0;
        end else begin
            filt_dly_q <= filt_dly_d;
            edge_q     <= edge_d;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            filt_len_q <= filt_len_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_det = ~filt_val & filt_dly_q;
            EDGE_ANY:  edge_det = filt_val ^ filt_dly_q;
            default:   edge_det = filt_val & ~filt_dly_q;
        endcase
    end

    always_comb begin
        edge_clr   = (wr_en && (address == ADDR_EDGE)) ? writedata : '0;
        filt_dly_d = filt_val;
        edge_d     = edge_det;
        // Set is OR-ed in after the clear so a coincident edge wins.
        edge_cap_d = (edge_cap_q & ~edge_clr) | edge_q;
        irq_mask_d = (wr_en && (address == ADDR_MASK)) ? writedata : irq_mask_q;
        filt_len_d = filt_wr ? filt_len_wr : filt_len_q;
    end

    always_comb begin
        case (address)
            ADDR_DATA: rd_mux = filt_val;
            ADDR_MASK: rd_mux = irq_mask_q;
            ADDR_EDGE: rd_mux = edge_cap_q;
            default:   rd_mux = filt_len_rd;
        endcase
        readdata_d = rd_en ? rd_mux : readdata_q;
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_axis_status_pio.sv
// Directed self-checking bench for axis_status_pio with default parameters.
module tb_axis_status_pio;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] address;
    logic       chipselect;
    logic       read_n;
    logic       write_n;
    logic [3:0] writedata;
    logic [3:0] in_port;
    logic [3:0] readdata;
    logic       irq;

    int total = 0;
    int bad   = 0;
    logic [3:0] rd;

    axis_status_pio dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [3:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = 4'h0;
        in_port    = 4'h0;
        idle(3);
        check("reset_irq", irq, 1'b0);
        check("reset_readdata", readdata, 4'h0);
        reset_n = 1'b1;
        idle(2);

        // Bypass filter: edge captured exactly 4 clk after pin change.
        bus_write(2'd1, 4'hF);
        in_port = 4'h1;
        idle(3);
        check("lat3_irq", irq, 1'b0);
        idle(1);
        check("lat4_irq", irq, 1'b1);
        bus_read(2'd2, rd);
        check("lat4_edge", rd, 4'h1);
        bus_write(2'd2, 4'h1);
        check("clr_irq", irq, 1'b0);

        // Glitch filter, filt_len=3.
        bus_write(2'd3, 4'h3);
        in_port = 4'h3;
        idle(2);
        in_port = 4'h1;
        idle(10);
        bus_read(2'd0, rd);
        check("glitch_data", rd, 4'h1);
        bus_read(2'd2, rd);
        check("glitch_edge", rd, 4'h0);
        in_port = 4'h3;
        idle(8);
        bus_read(2'd0, rd);
        check("hold_data", rd, 4'h3);
        bus_read(2'd2, rd);
        check("hold_edge", rd, 4'h2);

        // Write-1-to-clear and set-wins.
        bus_write(2'd3, 4'h0);
        bus_write(2'd2, 4'hF);
        in_port = 4'h2;
        idle(6);
        in_port = 4'h7;
        idle(6);
        bus_read(2'd2, rd);
        check("edge5", rd, 4'h5);
        bus_write(2'd2, 4'h1);
        bus_read(2'd2, rd);
        check("w1c_edge", rd, 4'h4);
        in_port = 4'h6;
        idle(6);
        in_port = 4'h7;
        idle(2);
        bus_write(2'd2, 4'h1);
        bus_read(2'd2, rd);
        check("set_wins", rd, 4'h5);

        // Mask gating of irq.
        bus_write(2'd2, 4'hF);
        bus_write(2'd1, 4'h1);
        in_port = 4'h5;
        idle(6);
        in_port = 4'h7;
        idle(6);
        bus_read(2'd2, rd);
        check("mask_edge", rd, 4'h2);
        check("mask_irq0", irq, 1'b0);
        bus_write(2'd1, 4'h2);
        check("mask_irq1", irq, 1'b1);

        // Register readback, address-0 write ignored, read does not clear.
        bus_write(2'd1, 4'hA);
        bus_read(2'd1, rd);
        check("mask_rd", rd, 4'hA);
        bus_write(2'd0, 4'h5);
        bus_read(2'd0, rd);
        check("data_rd", rd, 4'h7);
        bus_read(2'd1, rd);
        check("mask_keep", rd, 4'hA);
        bus_read(2'd3, rd);
        check("filt_rd", rd, 4'h0);
        bus_read(2'd2, rd);
        check("edge_rd1", rd, 4'h2);
        bus_read(2'd2, rd);
        check("edge_rd2", rd, 4'h2);
        idle(3);
        check("rd_hold", readdata, 4'h2);

        // Reset in the middle of a filter count.
        bus_write(2'd3, 4'h7);
        in_port = 4'hF;
        idle(5);
        reset_n = 1'b0;
        in_port = 4'h0;
        idle(2);
        check("rst_irq", irq, 1'b0);
        check("rst_readdata", readdata, 4'h0);
        reset_n = 1'b1;
        bus_read(2'd0, rd);
        check("rst_data", rd, 4'h0);
        bus_read(2'd1, rd);
        check("rst_mask", rd, 4'h0);
        bus_read(2'd3, rd);
        check("rst_filt", rd, 4'h0);
        idle(10);
        bus_read(2'd2, rd);
        check("rst_edge", rd, 4'h0);
        check("rst_irq_after", irq, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_status_pio.md
AXIS_STATUS_PIO -- requirements
Module: axis_status_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of status input bits.
REQ-002 The block SHALL have parameter EDGE_TYPE, default 0, meaning the captured edge: 0 rising, 1 falling, 2 any.
REQ-003 The block SHALL have parameter FILT_W, default 4, meaning the width of the glitch-filter length register.
REQ-004 The block SHALL have port clk  input  1  rising-edge system clock.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port address  input  2  register select.
REQ-007 The block SHALL have port chipselect  input  1  slave select.
REQ-008 The block SHALL have port read_n  input  1  active-low read strobe.
REQ-009 The block SHALL have port write_n  input  1  active-low write strobe.
REQ-010 The block SHALL have port writedata  input  WIDTH  write data.
REQ-011 The block SHALL have port in_port  input  WIDTH  asynchronous axis status pins.
REQ-012 The block SHALL have port readdata  output  WIDTH  registered read data.
REQ-013 The block SHALL have port irq  output  1  level interrupt request.

Function
REQ-014 in_port SHALL pass through a 2-flop synchronizer per bit; sync latency is 2 clk.
REQ-015 Each bit SHALL have a glitch filter: filtered value updates only after the synced bit differs from it for filt_len consecutive clk; the counter clears on any cycle of agreement.
REQ-016 filt_len = 0 SHALL bypass the filter (filtered = synced, no added latency).
REQ-017 A write to filt_len SHALL clear all filter counters in the same cycle.
REQ-018 Register map SHALL be: 0 data (RO, filtered value); 1 irqmask (RW); 2 edgecapture (R, write-1-to-clear); 3 filt_len (RW, low FILT_W bits).
REQ-019 Writes SHALL occur on chipselect & ~write_n; writes to address 0 are ignored.
REQ-020 readdata SHALL be registered: valid the clk after chipselect & ~read_n (read latency 1) and held until the next read; unused upper bits read 0.
REQ-021 Edge detect SHALL compare the filtered value with its one-cycle-delayed copy, per EDGE_TYPE.
REQ-022 A detected edge SHALL set its edgecapture bit on the next clk; the bit stays set until cleared.
REQ-023 If an edge and a write-1-clear hit the same bit in the same cycle, set SHALL win.
REQ-024 irq SHALL equal OR-reduce(edgecapture & irqmask), combinational from registers, no added latency.
REQ-025 A read of edgecapture SHALL NOT clear it.

Reset
REQ-026 On reset_n low, synchronizers, filtered values, delayed copies, filter counters, irqmask, edgecapture, filt_len and readdata SHALL go to 0; irq SHALL go to 0.
REQ-027 After reset release, no edge SHALL be captured until the filtered value first differs from 0.
REQ-028 Reset asserted mid-filter-count SHALL discard the partial count.

Structure
REQ-029 Register address constants (ADDR_DATA, ADDR_MASK, ADDR_EDGE, ADDR_FILT) and EDGE_TYPE encodings SHALL live in a shared package.
REQ-030 The per-bit synchronizer plus glitch filter SHALL be a sub-module axis_status_filt, instantiated WIDTH times.

Verification
REQ-031 filt_len=0, mask=4'hF, drive in_port bit0 0->1 -> edgecapture=4'h1 and irq=1 exactly 4 clk after the pin change.
REQ-032 filt_len=3, pulse bit1 high for 2 clk -> no data change, edgecapture=0; hold 3+ clk -> data bit1=1, edgecapture bit1 set.
REQ-033 edgecapture=4'h5, write 4'h1 to address 2 -> edgecapture=4'h4; write coincident with new bit0 edge -> bit0 remains 1.
REQ-034 edgecapture=4'h2, mask=4'h1 -> irq=0; write mask=4'h2 -> irq=1 the following cycle.
REQ-035 Read address 1 after writing 4'hA -> readdata=4'hA one clk after the read strobe; write to address 0 -> no register change.
REQ-036 Assert reset_n low mid-count with filt_len=7 -> all registers 0, irq=0; after release, no spurious edge.
